pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32, payload data width in bits; legal range 1..256.
REQ-002 Parameter CTRL_W, default 8, control-bundle width in bits, e.g. MemtoReg/RegWrite/MemWrite; legal range 1..64.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 FLUSH  input  1  synchronous discard of all held entries.
REQ-006 IN_VALID  input  1  upstream offers an entry.
REQ-007 IN_READY  output  1  stage accepts an entry this cycle.
REQ-008 IN_CTRL  input  CTRL_W  upstream control bundle.
REQ-009 IN_DATA  input  DATA_W  upstream payload.
REQ-010 OUT_VALID  output  1  stage presents an entry.
REQ-011 OUT_READY  input  1  downstream accepts the entry this cycle.
REQ-012 OUT_CTRL  output  CTRL_W  presented control bundle.
REQ-013 OUT_DATA  output  DATA_W  presented payload.
REQ-014 OCC  output  2  entries held: 0, 1 or 2.

Function
REQ-015 In-fire SHALL be IN_VALID & IN_READY; out-fire SHALL be OUT_VALID & OUT_READY.
REQ-016 Storage SHALL be a main slot plus a skid slot; FSM states EMPTY (OCC=0), FULL (OCC=1), SKID (OCC=2).
REQ-017 IN_READY SHALL be 1 in EMPTY and FULL and 0 in SKID, decoded from state only, with no combinational path from OUT_READY.
REQ-018 OUT_VALID SHALL be 1 in FULL and SKID; OUT_CTRL/OUT_DATA SHALL always come from the main slot.
REQ-019 EMPTY: in-fire SHALL load the main slot and go to FULL; otherwise stay EMPTY.
REQ-020 FULL with in-fire and out-fire SHALL load the main slot with the input and stay FULL.
REQ-021 FULL with out-fire only SHALL go to EMPTY.
REQ-022 FULL with in-fire only SHALL load the skid slot and go to SKID.
REQ-023 FULL with neither fire SHALL hold the main slot unchanged.
REQ-024 SKID with out-fire SHALL move the skid slot into the main slot and go to FULL; otherwise hold both slots.
REQ-025 Latency SHALL be 1 cycle: an entry accepted in EMPTY appears on OUT_* on the next cycle.
REQ-026 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by FLUSH.
REQ-027 FLUSH SHALL take priority over all transitions: next state EMPTY, and any in-fire in the same cycle SHALL be discarded.
REQ-028 An out-fire in a FLUSH cycle SHALL still count as delivered downstream.
REQ-029 Slot contents not overwritten SHALL retain their value, including across FLUSH.

Reset
REQ-030 While RST_N=0: state EMPTY, OCC=0, OUT_VALID=0, IN_READY=1, and both slots all-zero, so OUT_CTRL=0 and OUT_DATA=0.
REQ-031 Reset SHALL take effect immediately and asynchronously on RST_N falling, discarding any entries held mid-transfer.
REQ-032 Release of reset SHALL be synchronous-safe: the first state update occurs on the first CLK rising edge with RST_N=1.

Configuration
REQ-033 Macro PIPE_STAGE_BUBBLE_ZERO_EN: when defined, OUT_CTRL SHALL be forced to all-zero whenever OUT_VALID=0, so bubbles never assert control signals.
REQ-034 Without PIPE_STAGE_BUBBLE_ZERO_EN, OUT_CTRL SHALL show the main-slot control unchanged, possibly stale, while OUT_VALID=0.
REQ-035 OUT_DATA SHALL be unaffected by PIPE_STAGE_BUBBLE_ZERO_EN.

Verification
REQ-036 Reset, then IN_VALID=1 with IN_DATA=0x11 and OUT_READY=1 for one cycle -> next cycle OUT_VALID=1, OUT_DATA=0x11, OCC=1.
REQ-037 OUT_READY=0, push 0xA1 then 0xA2 -> OCC=2, IN_READY=0; then OUT_READY=1 -> outputs 0xA1, then 0xA2, then OUT_VALID=0.
REQ-038 Continuous IN_VALID=1 and OUT_READY=1 with 0x01..0x10 -> 16 outputs in order, one per cycle, OCC stays 1.
REQ-039 Hold in SKID with 0xB1/0xB2, assert FLUSH with IN_VALID=1 and IN_DATA=0xB3 -> next cycle OCC=0, OUT_VALID=0, and 0xB3 is never output.
REQ-040 RST_N low mid-stream with OCC=2 -> OUT_VALID=0 before the next clock edge and OCC=0; with PIPE_STAGE_BUBBLE_ZERO_EN defined, OUT_CTRL=0 after FLUSH, otherwise OUT_CTRL keeps its last value.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one-cycle pipeline register with a main slot and a skid slot (valid/ready both sides).
// Optional macro PIPE_STAGE_BUBBLE_ZERO_EN forces out_ctrl to zero whenever out_valid is low.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occ_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              in_fire_s;
  logic              out_fire_s;

  // Status flags {in_ready, out_valid, occ} that belong to a given state.
  function automatic logic [3:0] decode(input state_t s);
    logic [3:0] flags;
    case (s)
      EMPTY:   flags = {1'b1, 1'b0, 2'd0};
      FULL:    flags = {1'b1, 1'b1, 2'd1};
      SKID:    flags = {1'b0, 1'b1, 2'd2};
      default: flags = {1'b1, 1'b0, 2'd0};
    endcase
    return flags;
  endfunction

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Stage FSM: state, decoded status flags and both storage slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                           <= EMPTY;
      {in_ready_r, out_valid_r, occ_r}  <= decode(EMPTY);
      main_ctrl_r                       <= {CTRL_W{1'b0}};
      main_data_r                       <= {DATA_W{1'b0}};
      skid_ctrl_r                       <= {CTRL_W{1'b0}};
      skid_data_r                       <= {DATA_W{1'b0}};
    end else if (flush) begin
      // Slots keep their contents; only occupancy is discarded.
      state_r                          <= EMPTY;
      {in_ready_r, out_valid_r, occ_r} <= decode(EMPTY);
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_ctrl_r                      <= in_ctrl;
            main_data_r                      <= in_data;
            state_r                          <= FULL;
            {in_ready_r, out_valid_r, occ_r} <= decode(FULL);
          end
        end
        FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
          end else if (out_fire_s) begin
            state_r                          <= EMPTY;
            {in_ready_r, out_valid_r, occ_r} <= decode(EMPTY);
          end else if (in_fire_s) begin
            skid_ctrl_r                      <= in_ctrl;
            skid_data_r                      <= in_data;
            state_r                          <= SKID;
            {in_ready_r, out_valid_r, occ_r} <= decode(SKID);
          end
        end
        SKID: begin
          if (out_fire_s) begin
            main_ctrl_r                      <= skid_ctrl_r;
            main_data_r                      <= skid_data_r;
            state_r                          <= FULL;
            {in_ready_r, out_valid_r, occ_r} <= decode(FULL);
          end
        end
        default: begin
          state_r                          <= EMPTY;
          {in_ready_r, out_valid_r, occ_r} <= decode(EMPTY);
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign occ       = occ_r;
  assign out_data  = main_data_r;

`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
  assign out_ctrl = out_valid_r ? main_ctrl_r : {CTRL_W{1'b0}};
`else
  assign out_ctrl = main_ctrl_r;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based reference model plus directed literal checks.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = 8'h00;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;

  logic [39:0] mq[$];
  logic [39:0] shown = 40'h0;
  logic [31:0] log_q[$];
  logic        m_in_ok;
  logic        m_out_ok;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of at most two entries; the presented entry is the head, or the last head once empty.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      shown = 40'h0;
    end else begin
      m_in_ok  = mq.size() < 2;
      m_out_ok = mq.size() > 0;
      if (out_valid && out_ready) log_q.push_back(out_data);
      if (m_out_ok && out_ready) void'(mq.pop_front());
      if (in_valid && m_in_ok && !flush) mq.push_back({in_ctrl, in_data});
      if (flush) mq.delete();
      if (mq.size() > 0) shown = mq[0];
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [7:0] exp_ctrl;
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    exp_ctrl = (mq.size() > 0) ? shown[39:32] : 8'h00;
`else
    exp_ctrl = shown[39:32];
`endif
    chk("model_occ", 64'(occ), 64'(mq.size()));
    chk("model_in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("model_out_data", 64'(out_data), 64'(shown[31:0]));
    chk("model_out_ctrl", 64'(out_ctrl), 64'(exp_ctrl));
  end

  initial begin
    int found;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    #1 rst_n = 1'b1;
    cyc();

    // single entry, one-cycle latency
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h05; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'h11);
    chk("lat_occ", 64'(occ), 64'd1);
    cyc();
    chk("lat_drained_occ", 64'(occ), 64'd0);

    // fill both slots, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'h21;
    cyc();
    in_data = 32'hA2; in_ctrl = 8'h22;
    cyc();
    in_valid = 1'b0;
    chk("skid_occ", 64'(occ), 64'd2);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head", 64'(out_data), 64'hA1);
    out_ready = 1'b1;
    cyc();
    chk("drain_second", 64'(out_data), 64'hA2);
    chk("drain_second_valid", 64'(out_valid), 64'd1);
    cyc();
    chk("drain_empty_valid", 64'(out_valid), 64'd0);

    // streaming 0x01..0x10 at full rate
    log_q.delete();
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(i); out_ready = 1'b1;
      cyc();
      chk("stream_occ", 64'(occ), 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_count", 64'(log_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      chk("stream_order", 64'(log_q[i]), 64'(i + 1));

    // flush while in SKID discards the same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; in_ctrl = 8'hC1;
    cyc();
    in_data = 32'hB2; in_ctrl = 8'hC2;
    cyc();
    chk("flush_pre_occ", 64'(occ), 64'd2);
    flush = 1'b1; in_data = 32'hB3; in_ctrl = 8'hC3;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    chk("flush_out_ctrl", 64'(out_ctrl), 64'h00);
`else
    chk("flush_out_ctrl", 64'(out_ctrl), 64'hC1);
`endif
    out_ready = 1'b1;
    cyc();
    cyc();
    found = 0;
    foreach (log_q[k]) if (log_q[k] == 32'hB3) found++;
    chk("flush_b3_never_out", 64'(found), 64'd0);

    // asynchronous reset while two entries are held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD1; in_ctrl = 8'hE1;
    cyc();
    in_data = 32'hD2; in_ctrl = 8'hE2;
    cyc();
    in_valid = 1'b0;
    chk("areset_pre_occ", 64'(occ), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_occ", 64'(occ), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_out_data", 64'(out_data), 64'h0);
    #2 rst_n = 1'b1;
    cyc();

    // mixed traffic with back-pressure and a flush
    for (int i = 0; i < 48; i++) begin
      in_valid  = (i % 3) != 0;
      in_data   = 32'hC000_0000 + 32'(i);
      in_ctrl   = 8'(i + 1);
      out_ready = ((i % 4) != 1) && !(i >= 10 && i < 14);
      flush     = (i == 30);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    chk("final_occ", 64'(occ), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
